// File: rtl/dec2hex_converter_if.sv
// Handshake bundle between a requester (switch bank / button logic) and the
// BCD-to-binary converter. W must equal 4*DIGITS of the attached converter.
interface dec2hex_converter_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] bcd_in;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  error,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output error,
        output bin_out
    );
endinterface

// File: rtl/dec2hex_converter.sv
// Sequential BCD-to-binary converter (reverse double-dabble): one right shift
// plus per-digit "subtract 3 if >= 8" correction per cycle, W steps in total.
module dec2hex_converter #(
    parameter int DIGITS = 2
) (
    input  logic               clock,
    input  logic               reset,
    dec2hex_converter_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2*W-1:0]    r_work;
    logic [2*W-1:0]    w_shifted;
    logic [2*W-1:0]    w_stepped;
    logic [CW-1:0]     r_count;
    logic [DIGITS-1:0] w_digit_bad;
    logic              w_any_bad;
    logic              w_last_step;
    logic              r_error;
    logic [W-1:0]      r_bin_out;

    // Work register layout: {bcd[W-1:0], bin[W-1:0]}; the binary field fills from the top.
    assign w_shifted            = r_work >> 1;
    assign w_stepped[W-1:0]     = w_shifted[W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_digit_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
            // A digit >= 8 has its MSB set; the correction never borrows across digits.
            assign w_stepped[W + 4*gi +: 4] = w_shifted[W + 4*gi + 3]
                                            ? (w_shifted[W + 4*gi +: 4] - 4'd3)
                                            : w_shifted[W + 4*gi +: 4];
        end
    endgenerate

    assign w_any_bad   = |w_digit_bad;
    assign w_last_step = (r_count == CW'(W - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_any_bad ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_work    <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
            r_bin_out <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work  <= {bus.bcd_in, {W{1'b0}}};
                        r_count <= '0;
                        if (w_any_bad) begin
                            r_error   <= 1'b1;
                            r_bin_out <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_stepped;
                    r_count <= r_count + CW'(1);
                    // Results are committed on the edge into DONE so they are valid alongside done.
                    if (w_last_step) begin
                        r_bin_out <= w_stepped[W-1:0];
                        r_error   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.error   = r_error;
    assign bus.bin_out = r_bin_out;
endmodule

// File: tb/tb_dec2hex_converter.sv
// Randomized and directed checks of dec2hex_converter (DIGITS=2 and DIGITS=3)
// against an arithmetic BCD-value model.
module tb_dec2hex_converter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dec2hex_converter_if #(.W(8))  bus  ();
    dec2hex_converter_if #(.W(12)) bus3 ();

    dec2hex_converter #(.DIGITS(2)) dut  (.clock(clock), .reset(reset), .bus(bus));
    dec2hex_converter #(.DIGITS(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal value of the packed digits; any non-decimal digit flags an error with result 0.
    function automatic void ref_model(input logic [31:0] bcd, input int nd,
                                      output logic [31:0] val, output bit bad);
        int mult = 1;
        int acc  = 0;
        bad = 1'b0;
        for (int i = 0; i < nd; i++) begin
            int d = int'((bcd >> (4*i)) & 32'hF);
            if (d > 9) bad = 1'b1;
            acc += d * mult;
            mult *= 10;
        end
        val = bad ? 32'd0 : 32'(acc);
    endfunction

    task automatic convert(input logic [7:0] bcd, input bit disturb);
        logic [31:0] exp_v;
        bit          exp_bad;
        int          lat = 0;
        bit          busy_ok = 1'b1;
        int          extra_done = 0;
        logic [7:0]  held;
        ref_model({24'd0, bcd}, 2, exp_v, exp_bad);
        @(negedge clock);
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) bus.start = 1'b0;
            if (disturb && k == 3) begin
                bus.start  = 1'b1;
                bus.bcd_in = 8'h11;
            end
            if (disturb && k == 4) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        check("latency", 32'(lat), exp_bad ? 32'd1 : 32'd9);
        check("bin_out", {24'd0, bus.bin_out}, exp_v);
        check("error", {31'd0, bus.error}, {31'd0, exp_bad});
        check("busy_during", {31'd0, busy_ok}, 32'd1);
        if (!exp_bad) check("bcd_field_zero", {24'd0, dut.r_work[15:8]}, 32'd0);
        held = bus.bin_out;
        @(negedge clock);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("bin_held", {24'd0, bus.bin_out}, {24'd0, held});
        if (disturb) begin
            for (int k = 0; k < 12; k++) begin
                @(negedge clock);
                if (bus.done) extra_done++;
            end
            check("no_second_done", 32'(extra_done), 32'd0);
        end
        $display("txn w=8 bcd=%02h bin=%02h err=%0d lat=%0d", bcd, bus.bin_out, bus.error, lat);
    endtask

    task automatic convert3(input logic [11:0] bcd);
        logic [31:0] exp_v;
        bit          exp_bad;
        int          lat = 0;
        ref_model({20'd0, bcd}, 3, exp_v, exp_bad);
        @(negedge clock);
        bus3.bcd_in = bcd;
        bus3.start  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) bus3.start = 1'b0;
            if (bus3.done) begin
                lat = k;
                break;
            end
        end
        check("latency3", 32'(lat), exp_bad ? 32'd1 : 32'd13);
        check("bin_out3", {20'd0, bus3.bin_out}, exp_v);
        check("error3", {31'd0, bus3.error}, {31'd0, exp_bad});
        if (!exp_bad) check("bcd_field_zero3", {20'd0, dut3.r_work[23:12]}, 32'd0);
        $display("txn w=12 bcd=%03h bin=%03h err=%0d lat=%0d", bcd, bus3.bin_out, bus3.error, lat);
    endtask

    initial begin
        int          extra_done;
        logic [7:0]  r;
        logic [11:0] r3;
        bus.start   = 1'b0;
        bus.bcd_in  = '0;
        bus3.start  = 1'b0;
        bus3.bcd_in = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_bin", {24'd0, bus.bin_out}, 32'd0);
        check("rst_bin3", {20'd0, bus3.bin_out}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        convert(8'h99, 1'b0);
        convert(8'h00, 1'b0);
        convert(8'h42, 1'b0);
        convert(8'h1A, 1'b0);
        repeat (3) @(negedge clock);
        check("error_sticky", {31'd0, bus.error}, 32'd1);
        convert(8'h37, 1'b0);
        convert(8'h57, 1'b1);

        // Abort a conversion of 8'h88 partway through shifting.
        @(negedge clock);
        bus.bcd_in = 8'h88;
        bus.start  = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_bin", {24'd0, bus.bin_out}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b1;
        extra_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (bus.done) extra_done++;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        convert(8'h88, 1'b0);

        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                r = {4'(t), 4'(o)};
                convert(r, 1'b0);
            end
        end
        for (int n = 0; n < 40; n++) begin
            r = 8'($urandom_range(0, 255));
            convert(r, 1'b0);
        end

        convert3(12'h999);
        convert3(12'h100);
        convert3(12'h1A0);
        for (int n = 0; n < 10; n++) begin
            r3 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert3(r3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
